// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Holds the program counter, reads the synchronous instruction memory and
// hands one 32-bit instruction at a time to the decoder. Exactly one
// instruction is in flight: after decode_en is pulsed the unit waits for the
// execute/writeback path to report exec_done, then redirects the PC from the
// jr/jump/branch information returned with it (or halts on exit).
//
// Instruction cycle: FETCH -> MEM -> ISSUE -> WAIT_EXEC (>= 4 clocks).
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             leave IDLE and begin fetching at pc
//   imem_addr         instruction memory word address (always equals pc)
//   imem_rdata        instruction memory read data, one cycle after address
//   instr             registered instruction presented to the decoder
//   decode_en         one-cycle decoder enable per instruction
//   pc                word address of the instruction held in instr
//   exec_done         one-cycle completion pulse from execute/writeback
//   branch_taken      taken beq, qualified by exec_done
//   branch_offset     sign-extended word offset, qualified by exec_done
//   jump, jump_target j/jal and its 26-bit word target
//   jr, jr_target     jr and the register word address
//   exit_instruction  stop execution, qualified by exec_done
//   halted            high while halted (left only by reset)
//   instr_count       retired instruction counter (wraps at 2^32)
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int          ADDR_WIDTH = 10,
  parameter int unsigned RESET_PC   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [31:0]           imem_rdata,
  output logic [31:0]           instr,
  output logic                  decode_en,
  output logic [ADDR_WIDTH-1:0] pc,
  input  logic                  exec_done,
  input  logic                  branch_taken,
  input  logic signed [31:0]    branch_offset,
  input  logic                  jump,
  input  logic [25:0]           jump_target,
  input  logic                  jr,
  input  logic [31:0]           jr_target,
  input  logic                  exit_instruction,
  output logic                  halted,
  output logic [31:0]           instr_count
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    MEM,
    ISSUE,
    WAIT_EXEC,
    HALT
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] RESET_PC_A = ADDR_WIDTH'(RESET_PC);

  state_t                  state;
  state_t                  state_nxt;
  logic [ADDR_WIDTH-1:0]   next_pc;
  logic                    retire;

  // Redirect priority: jr > jump > taken branch > sequential. All arithmetic
  // is modulo 2^ADDR_WIDTH, so wrapping past the top of memory is silent.
  function automatic logic [ADDR_WIDTH-1:0] calc_next_pc(
    input logic [ADDR_WIDTH-1:0] cur,
    input logic                  br,
    input logic signed [31:0]    off,
    input logic                  jp,
    input logic [25:0]           jt,
    input logic                  jrx,
    input logic [31:0]           jrt
  );
    logic [ADDR_WIDTH-1:0] seq;
    seq = cur + ADDR_WIDTH'(1);
    if (jrx)
      return ADDR_WIDTH'(jrt);
    else if (jp)
      return ADDR_WIDTH'(jt);
    else if (br)
      return seq + ADDR_WIDTH'(off);
    else
      return seq;
  endfunction

  assign next_pc = calc_next_pc(pc, branch_taken, branch_offset, jump,
                                jump_target, jr, jr_target);

  // Control inputs only matter in the exec_done cycle of WAIT_EXEC.
  assign retire = (state == WAIT_EXEC) && exec_done;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (start) state_nxt = FETCH;
      FETCH:     state_nxt = MEM;
      MEM:       state_nxt = ISSUE;
      ISSUE:     state_nxt = WAIT_EXEC;
      WAIT_EXEC: if (exec_done) state_nxt = exit_instruction ? HALT : FETCH;
      HALT:      state_nxt = HALT;
      default:   state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // MEM -> ISSUE boundary: capture the memory word into instr; WAIT_EXEC
  // retirement updates pc and instr_count.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC_A;
      instr       <= '0;
      instr_count <= '0;
    end else begin
      if (state == MEM)
        instr <= imem_rdata;
      if (retire) begin
        instr_count <= instr_count + 32'd1;
        // On exit pc stays on the exit instruction.
        if (!exit_instruction)
          pc <= next_pc;
      end
    end
  end

  // The memory address simply follows pc: it is presented in FETCH and the
  // synchronous read returns during MEM.
  assign imem_addr = pc;
  assign decode_en = (state == ISSUE);
  assign halted    = (state == HALT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Drives instr_fetch_unit against a randomly filled instruction memory and a
// reference model of the program flow (pc as an integer, updated with modulo
// arithmetic from the redirect rules, plus a retired-instruction count).
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata = '0;
  logic [31:0]   instr;
  logic          decode_en;
  logic [AW-1:0] pc;
  logic          exec_done = 1'b0;
  logic          branch_taken = 1'b0;
  logic [31:0]   branch_offset = '0;
  logic          jump = 1'b0;
  logic [25:0]   jump_target = '0;
  logic          jr = 1'b0;
  logic [31:0]   jr_target = '0;
  logic          exit_instruction = 1'b0;
  logic          halted;
  logic [31:0]   instr_count;

  int checks = 0;
  int errors = 0;
  int model_pc = 0;
  int model_count = 0;
  int cyc = 0;

  logic [31:0] imem [DEPTH];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) imem_rdata <= imem[imem_addr];

  instr_fetch_unit #(.ADDR_WIDTH(AW), .RESET_PC(0)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .imem_addr        (imem_addr),
    .imem_rdata       (imem_rdata),
    .instr            (instr),
    .decode_en        (decode_en),
    .pc               (pc),
    .exec_done        (exec_done),
    .branch_taken     (branch_taken),
    .branch_offset    (branch_offset),
    .jump             (jump),
    .jump_target      (jump_target),
    .jr               (jr),
    .jr_target        (jr_target),
    .exit_instruction (exit_instruction),
    .halted           (halted),
    .instr_count      (instr_count)
  );

  // Reference next-PC: the redirect rules evaluated as integer arithmetic.
  function automatic int ref_next(int p, bit br, logic [31:0] off, bit jp,
                                  logic [25:0] jt, bit jrx, logic [31:0] jrt);
    if (jrx) return int'(jrt % DEPTH);
    if (jp)  return int'(jt % DEPTH);
    if (br)  return (p + 1 + int'(off % DEPTH)) % DEPTH;
    return (p + 1) % DEPTH;
  endfunction

  // Wait (bounded) for the next decode_en, returning at the negedge where it
  // is seen high.
  task automatic wait_decode(output bit timeout);
    timeout = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (decode_en === 1'b1) begin
        timeout = 1'b0;
        break;
      end
    end
  endtask

  // From the ISSUE cycle: stall 'delay' cycles in WAIT_EXEC, then pulse
  // exec_done with the given controls and update the reference model.
  // stall_ok reports whether decode_en stayed low and instr stayed stable.
  task automatic retire(input int delay, input bit br, input logic [31:0] off,
                        input bit jp, input logic [25:0] jt, input bit jrx,
                        input logic [31:0] jrt, input bit ex,
                        output bit stall_ok);
    logic [31:0] held;
    held = instr;
    stall_ok = 1'b1;
    @(negedge clk);
    for (int i = 0; i < delay; i++) begin
      if (decode_en !== 1'b0 || instr !== held) stall_ok = 1'b0;
      @(negedge clk);
    end
    if (decode_en !== 1'b0 || instr !== held) stall_ok = 1'b0;
    exec_done = 1'b1; branch_taken = br; branch_offset = off; jump = jp;
    jump_target = jt; jr = jrx; jr_target = jrt; exit_instruction = ex;
    @(negedge clk);
    exec_done = 1'b0; branch_taken = 1'b0; branch_offset = '0; jump = 1'b0;
    jump_target = '0; jr = 1'b0; jr_target = '0; exit_instruction = 1'b0;
    model_count++;
    if (!ex) model_pc = ref_next(model_pc, br, off, jp, jt, jrx, jrt);
  endtask

  // Retire the current instruction with a jump to tgt.
  task automatic advance(input int tgt, output bit timeout);
    bit ok;
    wait_decode(timeout);
    retire(0, 0, '0, 1, 26'(tgt), 0, '0, 0, ok);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (pc !== AW'(0)) begin errors++; $display("FAIL reset_pc: got %0h expected 0", pc); end
    checks++; if (imem_addr !== AW'(0)) begin errors++; $display("FAIL reset_imem_addr: got %0h expected 0", imem_addr); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %0h expected 0", instr); end
    checks++; if (decode_en !== 1'b0) begin errors++; $display("FAIL reset_decode_en: got %b expected 0", decode_en); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
    checks++; if (instr_count !== 32'h0) begin errors++; $display("FAIL reset_count: got %0d expected 0", instr_count); end
    @(negedge clk);
    rst_n = 1'b1;
    model_pc = 0;
    model_count = 0;
  endtask

  task automatic test_sequential();
    bit to, ok;
    int last;
    last = 0;
    start = 1'b1;   // held high: must not re-trigger anything
    for (int k = 0; k < 3; k++) begin
      wait_decode(to);
      checks++; if (to) begin errors++; $display("FAIL seq_decode_timeout: got none expected decode_en (k=%0d)", k); end
      checks++; if (pc !== AW'(k)) begin errors++; $display("FAIL seq_pc: got %0d expected %0d", pc, k); end
      checks++; if (instr !== imem[k]) begin errors++; $display("FAIL seq_instr: got %h expected %h", instr, imem[k]); end
      if (k > 0) begin
        checks++; if (cyc - last != 4) begin errors++; $display("FAIL seq_spacing: got %0d expected 4", cyc - last); end
      end
      last = cyc;
      retire(0, 0, '0, 0, '0, 0, '0, 0, ok);
    end
    start = 1'b0;
    checks++; if (instr_count !== 32'd3) begin errors++; $display("FAIL seq_count: got %0d expected 3", instr_count); end
  endtask

  task automatic test_branch();
    bit to, ok;
    advance(5, to);
    wait_decode(to);
    checks++; if (pc !== AW'(5)) begin errors++; $display("FAIL br_setup_pc: got %0d expected 5", pc); end
    retire(0, 1, 32'hFFFF_FFFD, 0, '0, 0, '0, 0, ok);
    wait_decode(to);
    checks++; if (pc !== AW'(3)) begin errors++; $display("FAIL br_back_pc: got %0d expected 3", pc); end
    checks++; if (instr !== imem[3]) begin errors++; $display("FAIL br_back_instr: got %h expected %h", instr, imem[3]); end
    retire(0, 0, '0, 1, 26'd5, 0, '0, 0, ok);
    wait_decode(to);
    retire(0, 1, 32'd4, 0, '0, 0, '0, 0, ok);
    wait_decode(to);
    checks++; if (pc !== AW'(10)) begin errors++; $display("FAIL br_fwd_pc: got %0d expected 10", pc); end
    checks++; if (instr !== imem[10]) begin errors++; $display("FAIL br_fwd_instr: got %h expected %h", instr, imem[10]); end
  endtask

  task automatic test_jump_priority();
    bit to, ok;
    retire(0, 0, '0, 1, 26'd7, 0, '0, 0, ok);
    wait_decode(to);
    checks++; if (pc !== AW'(7)) begin errors++; $display("FAIL jp_setup_pc: got %0d expected 7", pc); end
    retire(0, 1, 32'd100, 1, 26'h000020, 0, '0, 0, ok);
    wait_decode(to);
    checks++; if (pc !== AW'('h20)) begin errors++; $display("FAIL jump_over_branch: got %0h expected 20", pc); end
    retire(0, 1, 32'd3, 1, 26'h000100, 1, 32'h15, 0, ok);
    wait_decode(to);
    checks++; if (pc !== AW'('h15)) begin errors++; $display("FAIL jr_over_jump: got %0h expected 15", pc); end
    checks++; if (instr !== imem['h15]) begin errors++; $display("FAIL jr_instr: got %h expected %h", instr, imem['h15]); end
  endtask

  task automatic test_wrap();
    bit to, ok;
    retire(0, 0, '0, 1, 26'd1023, 0, '0, 0, ok);
    wait_decode(to);
    checks++; if (pc !== AW'(1023)) begin errors++; $display("FAIL wrap_setup_pc: got %0d expected 1023", pc); end
    retire(0, 0, '0, 0, '0, 0, '0, 0, ok);
    wait_decode(to);
    checks++; if (pc !== AW'(0)) begin errors++; $display("FAIL wrap_seq_pc: got %0d expected 0", pc); end
    retire(0, 0, '0, 1, 26'd1020, 0, '0, 0, ok);
    wait_decode(to);
    retire(0, 1, 32'd5, 0, '0, 0, '0, 0, ok);
    wait_decode(to);
    checks++; if (pc !== AW'(2)) begin errors++; $display("FAIL wrap_branch_pc: got %0d expected 2", pc); end
    checks++; if (instr !== imem[2]) begin errors++; $display("FAIL wrap_branch_instr: got %h expected %h", instr, imem[2]); end
  endtask

  task automatic test_stall();
    bit to, ok;
    int cnt_before;
    retire(10, 0, '0, 0, '0, 0, '0, 0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_hold: got decode_en/instr change expected quiet wait"); end
    // A stray exec_done during FETCH must be ignored.
    cnt_before = model_count;
    exec_done = 1'b1; jump = 1'b1; jump_target = 26'h3FF;
    @(negedge clk);
    exec_done = 1'b0; jump = 1'b0; jump_target = '0;
    wait_decode(to);
    checks++; if (pc !== AW'(model_pc)) begin errors++; $display("FAIL stray_done_pc: got %0d expected %0d", pc, model_pc); end
    checks++; if (instr_count !== 32'(cnt_before)) begin errors++; $display("FAIL stray_done_count: got %0d expected %0d", instr_count, cnt_before); end
  endtask

  task automatic test_random();
    bit to, ok;
    bit br, jp, jrx;
    logic [31:0] off, jrt;
    logic [25:0] jt;
    for (int n = 0; n < 40; n++) begin
      br  = 1'($urandom_range(0, 1));
      jp  = ($urandom_range(0, 3) == 0);
      jrx = ($urandom_range(0, 5) == 0);
      off = $urandom;
      jt  = 26'($urandom);
      jrt = $urandom;
      retire($urandom_range(0, 3), br, off, jp, jt, jrx, jrt, 0, ok);
      wait_decode(to);
      checks++; if (to || pc !== AW'(model_pc)) begin errors++; $display("FAIL rand_pc: got %0d expected %0d (iter %0d)", pc, model_pc, n); end
      checks++; if (instr !== imem[model_pc]) begin errors++; $display("FAIL rand_instr: got %h expected %h (iter %0d)", instr, imem[model_pc], n); end
    end
  endtask

  task automatic test_exit();
    bit to, ok;
    bit seen;
    logic [31:0] held;
    retire(0, 0, '0, 1, 26'd9, 0, '0, 0, ok);
    wait_decode(to);
    checks++; if (pc !== AW'(9)) begin errors++; $display("FAIL exit_setup_pc: got %0d expected 9", pc); end
    held = instr;
    retire(0, 1, 32'd7, 1, 26'd40, 0, '0, 1, ok);
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL exit_halted: got %b expected 1", halted); end
    checks++; if (pc !== AW'(9)) begin errors++; $display("FAIL exit_pc: got %0d expected 9", pc); end
    checks++; if (instr_count !== 32'(model_count)) begin errors++; $display("FAIL exit_count: got %0d expected %0d", instr_count, model_count); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (decode_en !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    checks++; if (seen) begin errors++; $display("FAIL halt_decode: got decode_en pulse expected none"); end
    checks++; if (halted !== 1'b1 || pc !== AW'(9) || instr !== held) begin errors++; $display("FAIL halt_frozen: got halted=%b pc=%0d instr=%h expected 1/9/%h", halted, pc, instr, held); end
  endtask

  task automatic test_reset_mid();
    bit to, ok;
    bit seen;
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_from_halt: got halted=%b expected 0", halted); end
    rst_n = 1'b1;
    model_pc = 0;
    model_count = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    advance(300, to);
    wait_decode(to);
    @(negedge clk);   // now in WAIT_EXEC for pc 300
    #2 rst_n = 1'b0;
    #1;
    checks++; if (pc !== AW'(0) || imem_addr !== AW'(0)) begin errors++; $display("FAIL midrst_pc: got pc=%0d addr=%0d expected 0", pc, imem_addr); end
    checks++; if (decode_en !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL midrst_ctrl: got decode_en=%b halted=%b expected 0", decode_en, halted); end
    checks++; if (instr_count !== 32'd0) begin errors++; $display("FAIL midrst_count: got %0d expected 0", instr_count); end
    @(negedge clk);
    rst_n = 1'b1;
    model_pc = 0;
    model_count = 0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (decode_en !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL midrst_idle: got decode_en expected IDLE"); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_decode(to);
    checks++; if (to || pc !== AW'(0) || instr !== imem[0]) begin errors++; $display("FAIL midrst_restart: got pc=%0d instr=%h expected 0/%h", pc, instr, imem[0]); end
    retire(0, 0, '0, 0, '0, 0, '0, 0, ok);
    checks++; if (instr_count !== 32'd1) begin errors++; $display("FAIL midrst_count_after: got %0d expected 1", instr_count); end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++)
      imem[i] = ($urandom & 32'hFFFF_FC00) | 32'(i);
    test_reset();
    test_sequential();
    test_branch();
    test_jump_priority();
    test_wrap();
    test_stall();
    test_random();
    test_exit();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream neighbour of the instruction decoder: holds the program counter, reads instruction memory and presents one 32-bit instruction per instruction cycle on `instr`.
- Pulses the decoder enable, then waits for the execute/writeback path to report completion.
- Computes the next PC from the branch/jump/jr/exit information returned by that path.
- Multi-cycle and non-pipelined: exactly one instruction in flight.

Parameters:
ADDR_WIDTH, 10, width of word-addressed PC and instruction-memory address
RESET_PC, 0, PC value loaded on reset (word address)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin execution from current PC (sampled only in IDLE)
imem_addr  output  ADDR_WIDTH  instruction memory word address
imem_rdata  input  32  instruction memory data, synchronous read, valid 1 cycle after address
instr  output  32  registered instruction to decoder
decode_en  output  1  decoder enable, one-cycle pulse per instruction
pc  output  ADDR_WIDTH  address of instruction currently held in instr
exec_done  input  1  one-cycle pulse: current instruction finished execute/writeback
branch_taken  input  1  beq resolved taken (Branch & alu_zero), valid with exec_done
branch_offset  input  32  sign-extended immediate (words), valid with exec_done
jump  input  1  j/jal, valid with exec_done
jump_target  input  26  instr[25:0] word target, valid with exec_done
jr  input  1  jr, valid with exec_done
jr_target  input  32  rs register value (word address), valid with exec_done
exit_instruction  input  1  exit opcode decoded, valid with exec_done
halted  output  1  high in HALT state
instr_count  output  32  number of instructions retired

Behaviour:
Reset values (async, rst_n=0):
- state=IDLE, pc=RESET_PC, imem_addr=RESET_PC, instr=0, decode_en=0, halted=0, instr_count=0.
- Reset asserted in any state aborts the in-flight instruction with no retirement.

States and transitions:
- IDLE: imem_addr=pc; start=1 -> FETCH.
- FETCH (1 cycle): imem_addr=pc -> MEM.
- MEM (1 cycle): instr <= imem_rdata -> ISSUE.
- ISSUE (1 cycle): decode_en=1, instr held stable -> WAIT_EXEC.
- WAIT_EXEC: decode_en=0, instr held; waits any number of cycles for exec_done.
  - On exec_done: instr_count <= instr_count+1 (wraps at 2^32).
  - exit_instruction=1 -> HALT, pc unchanged.
  - otherwise pc <= next_pc and -> FETCH.
- HALT: halted=1, decode_en=0, pc/instr/instr_count frozen. Left only by reset; start is ignored.

next_pc, priority exit > jr > jump > branch > sequential:
- jr: jr_target[ADDR_WIDTH-1:0]
- jump: jump_target[ADDR_WIDTH-1:0]
- branch_taken: pc + 1 + branch_offset[ADDR_WIDTH-1:0]
- else: pc + 1
- All arithmetic is modulo 2^ADDR_WIDTH; wrap from max address to 0 is legal and silent.

Timing and boundary conditions:
- Minimum instruction cycle is 4 clocks (FETCH, MEM, ISSUE, WAIT_EXEC with exec_done in its first cycle).
- decode_en is high exactly 1 cycle per instruction and never while exec_done is awaited.
- exec_done outside WAIT_EXEC is ignored.
- Control inputs are sampled only in the exec_done cycle.
- start held high continuously does not re-trigger; it is only meaningful in IDLE.
- Simultaneous flags resolve by the priority above (e.g. jump=1 and branch_taken=1 -> jump wins).
- jal link-register writeback is the datapath's concern; this block only redirects the PC.

Test Plan:
- Sequential fetch:
  - Stimulus: reset, imem[0..2]=distinct words, start, exec_done one cycle after each decode_en.
  - Required: instr=imem[0],[1],[2] in order; pc=0,1,2; decode_en pulses 4 clocks apart; instr_count=3.
- Branch:
  - Stimulus: pc=5, branch_taken=1, branch_offset=0xFFFFFFFD (-3).
  - Required: next pc=3.
  - Stimulus: branch_offset=4.
  - Required: next pc=10.
- Jump priority:
  - Stimulus: at pc=7, jump=1, jump_target=0x000020, branch_taken=1.
  - Required: pc=0x20.
  - Stimulus: jr=1, jr_target=0x15 together with jump=1.
  - Required: pc=0x15.
- Wrap-around:
  - Stimulus: ADDR_WIDTH=10, pc=1023, sequential.
  - Required: pc=0.
  - Stimulus: pc=1020, branch_offset=5.
  - Required: pc=2.
- Exit and stall:
  - Stimulus: exec_done delayed 10 cycles.
  - Required: decode_en low and instr stable throughout the wait.
  - Stimulus: exit_instruction=1 with exec_done at pc=9.
  - Required: halted=1, pc=9, no further decode_en even with start pulsed.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 asynchronously during WAIT_EXEC.
  - Required: immediately pc=RESET_PC, decode_en=0, instr_count=0, state IDLE; restart fetches from RESET_PC.
